// File: rtl/uart_pwd_rx.sv
// UART (8N1) receiver that turns host-typed hex characters, CR and ESC into
// the same digit/enter/clear events the password-entry FSM gets from the board keys.
module uart_pwd_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       rx,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       enter,
    output logic       clear,
    output logic       bad_char,
    output logic       framing_err,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             enter_q, enter_d;
    logic             clear_q, clear_d;
    logic             bad_char_q, bad_char_d;
    logic             framing_err_q, framing_err_d;
    logic             busy_q, busy_d;
    logic             expired;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            enter_q       <= 1'b0;
            clear_q       <= 1'b0;
            bad_char_q    <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            enter_q       <= enter_d;
            clear_q       <= clear_d;
            bad_char_q    <= bad_char_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

    // Frame sequencing plus byte decode; the counter expires on the edge where it reads 1.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        enter_d       = 1'b0;
        clear_d       = 1'b0;
        bad_char_d    = 1'b0;
        framing_err_d = 1'b0;

        if ((state_q == S_START || state_q == S_DATA || state_q == S_STOP) && !expired) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = CNT_W'(HALF_BIT);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expired) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d     = CNT_W'(CLKS_PER_BIT);
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = CNT_W'(CLKS_PER_BIT);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (expired) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (shift_q >= 8'h30 && shift_q <= 8'h39) begin
                            digit_d       = shift_q[3:0];
                            digit_valid_d = 1'b1;
                        end else if ((shift_q >= 8'h41 && shift_q <= 8'h46) ||
                                     (shift_q >= 8'h61 && shift_q <= 8'h66)) begin
                            digit_d       = shift_q[3:0] + 4'd9;
                            digit_valid_d = 1'b1;
                        end else if (shift_q == 8'h0D) begin
                            enter_d = 1'b1;
                        end else if (shift_q == 8'h1B) begin
                            clear_d = 1'b1;
                        end else begin
                            bad_char_d = 1'b1;
                        end
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A break parked in WAIT_HIGH is not an active frame.
        busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    end

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign enter       = enter_q;
    assign clear       = clear_q;
    assign bad_char    = bad_char_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule
